// File: rtl/list_packer.sv
// list_packer: packs a stream of words into 8-word packets (header + up to 7 payload words)
module list_packer #(
    parameter int DW = 32
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [DW-1:0]       s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    output logic [7:0][DW-1:0]  OUT,
    output logic                o_valid,
    input  logic                i_ready
);
    logic [7:1][DW-1:0] fill_buf;
    logic [2:0]         fill_cnt;
    logic               fill_full;
    logic               seq;
    logic               accept;
    logic               xfer;
    logic [7:0][DW-1:0] pkt;
    assign s_ready = ~fill_full;
    assign accept  = s_valid & ~fill_full;
    assign xfer    = fill_full & (~o_valid | i_ready);
    // next packet image: header with seq and count, payload beyond count forced to zero
    always_comb begin
        pkt       = '0;
        pkt[0][4:0] = {1'b0, fill_cnt, seq};
        for (int i = 1; i < 8; i++)
            pkt[i] = (3'(i) <= fill_cnt) ? fill_buf[i] : '0;
    end
    // fill buffer, output register and handshake state
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fill_buf  <= '0;
            fill_cnt  <= '0;
            fill_full <= 1'b0;
            o_valid   <= 1'b0;
            seq       <= 1'b0;
            OUT       <= {{(8*DW-1){1'b0}}, 1'b1};
        end else begin
            if (accept) begin
                fill_buf[fill_cnt + 3'd1] <= s_data;
                fill_cnt                  <= fill_cnt + 3'd1;
                fill_full                 <= s_last | (fill_cnt == 3'd6);
            end
            if (xfer) begin
                OUT       <= pkt;
                seq       <= ~seq;
                fill_cnt  <= '0;
                fill_full <= 1'b0;
            end
            o_valid <= xfer | (o_valid & ~i_ready);
        end
    end
endmodule
